crc16_tx_gen: RTL and testbench

- Sequential USB CRC16 generator for the transmit path.
- Takes the 64-bit encrypted payload when encryption completes and computes the USB DATA-packet CRC16 over it, a few bits per clock.
- Presents the result plus a done level to the packet combiner (CRC16_out / CRC_done inputs), which currently receives a constant 16'hFFFF.
- Algorithm is CRC-16/USB:
  - poly 0x8005, init 0xFFFF, reflected in/out, final XOR 0xFFFF.
  - Catalogue check for ASCII "123456789" is 0xB4C8.

---
 rtl/crc16_tx_gen.sv | 119 +++++++++++
 tb/tb_crc16_tx_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_tx_gen.sv
// Sequential CRC-16/USB generator for the transmit path. It folds BITS_PER_CYCLE payload bits per clock.
// Optional received-CRC checking is enabled by defining CRC16_TX_CHECK_EN.
module crc16_tx_gen #(
   parameter int DATA_BITS      = 64,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data_in,
`ifdef CRC16_TX_CHECK_EN
   input  logic [15:0]          crc_in,
   output logic                 crc_err,
`endif
   output logic [15:0]          crc16_out,
   output logic                 crc_done,
   output logic                 busy
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [15:0]          crc_q, crc_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [15:0]          out_q, out_d;
`ifdef CRC16_TX_CHECK_EN
   logic [15:0]          crc_in_q, crc_in_d;
   logic                 err_q, err_d;
`endif

   // Reflected form of poly 0x8005: shift right, XOR 0xA001 on feedback.
   function automatic logic [15:0] crc_fold(input logic [15:0] crc,
                                            input logic [BITS_PER_CYCLE-1:0] bits);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         fb = c[0] ^ bits[i];
         c  = c >> 1;
         if (fb) c = c ^ 16'hA001;
      end
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
`ifdef CRC16_TX_CHECK_EN
      crc_in_d = crc_in_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               shift_d = data_in;
               crc_d   = 16'hFFFF;
               cnt_d   = '0;
               state_d = RUN;
`ifdef CRC16_TX_CHECK_EN
               crc_in_d = crc_in;
               err_d    = 1'b0;
`endif
            end
         end
         RUN: begin
            crc_d   = crc_fold(crc_q, shift_q[BITS_PER_CYCLE-1:0]);
            shift_d = shift_q >> BITS_PER_CYCLE;
            cnt_d   = cnt_q + CNT_W'(BITS_PER_CYCLE);
            // Exact terminal compare; the counter never wraps.
            if (cnt_d == CNT_W'(DATA_BITS)) begin
               out_d   = ~crc_d;
               state_d = DONE;
`ifdef CRC16_TX_CHECK_EN
               err_d = (~crc_d != crc_in_q);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         crc_q   <= 16'hFFFF;
         shift_q <= '0;
         cnt_q   <= '0;
         out_q   <= 16'h0000;
`ifdef CRC16_TX_CHECK_EN
         crc_in_q <= 16'h0000;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
`ifdef CRC16_TX_CHECK_EN
         crc_in_q <= crc_in_d;
         err_q    <= err_d;
`endif
      end
   end

   assign crc16_out = out_q;
   assign crc_done  = (state_q == DONE);
   assign busy      = (state_q == RUN);
`ifdef CRC16_TX_CHECK_EN
   assign crc_err   = err_q;
`endif

endmodule

// File: tb/tb_crc16_tx_gen.sv
// Bench for crc16_tx_gen: three instances (64b x1, 72b x1, 72b x8) checked against a byte-wise CRC-16/USB model.
// CRC16_TX_CHECK_EN, when defined, also exercises crc_in/crc_err.
module tb_crc16_tx_gen;

   logic        clk;
   logic        n_rst;
   logic        st   [3];
   logic [71:0] din  [3];
   logic [15:0] q_out[3];
   logic        q_done[3];
   logic        q_busy[3];
   logic [15:0] ci   [3];
   logic        ce   [3];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic        m_busy[3];
   logic        m_done[3];
   logic [15:0] m_out [3];
   logic        m_err [3];
   logic [71:0] m_data[3];
   logic [15:0] m_ci  [3];
   int          m_left[3];

   localparam logic [71:0] ASCII = 72'h39_38_37_36_35_34_33_32_31;

   crc16_tx_gen #(.DATA_BITS(64), .BITS_PER_CYCLE(1)) dut0 (
      .clk(clk), .n_rst(n_rst), .start(st[0]), .data_in(din[0][63:0]),
`ifdef CRC16_TX_CHECK_EN
      .crc_in(ci[0]), .crc_err(ce[0]),
`endif
      .crc16_out(q_out[0]), .crc_done(q_done[0]), .busy(q_busy[0]));

   crc16_tx_gen #(.DATA_BITS(72), .BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .n_rst(n_rst), .start(st[1]), .data_in(din[1]),
`ifdef CRC16_TX_CHECK_EN
      .crc_in(ci[1]), .crc_err(ce[1]),
`endif
      .crc16_out(q_out[1]), .crc_done(q_done[1]), .busy(q_busy[1]));

   crc16_tx_gen #(.DATA_BITS(72), .BITS_PER_CYCLE(8)) dut2 (
      .clk(clk), .n_rst(n_rst), .start(st[2]), .data_in(din[2]),
`ifdef CRC16_TX_CHECK_EN
      .crc_in(ci[2]), .crc_err(ce[2]),
`endif
      .crc16_out(q_out[2]), .crc_done(q_done[2]), .busy(q_busy[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Textbook non-reflected CRC-16 on 0x8005 with explicit input/output bit reversal.
   function automatic logic [15:0] crc_usb(input logic [71:0] d, input int nb);
      logic [15:0] c;
      logic [15:0] r;
      logic [7:0]  b;
      logic [7:0]  rb;
      c = 16'hFFFF;
      for (int i = 0; i < nb; i++) begin
         b = d[8*i +: 8];
         for (int j = 0; j < 8; j++) rb[j] = b[7-j];
         c = c ^ {rb, 8'h00};
         for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
      end
      for (int j = 0; j < 16; j++) r[j] = c[15-j];
      return ~r;
   endfunction

   function automatic int ncyc(input int i);
      return (i == 0) ? 64 : (i == 1) ? 72 : 9;
   endfunction

   function automatic int nbytes(input int i);
      return (i == 0) ? 8 : 9;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at cyc %0d", name, act, exp, cyc);
      end
   endtask

   // Cycle model: a start while idle loads a countdown; the result appears when it expires.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < 3; i++) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b0;
            m_out[i]  <= 16'h0000;
            m_err[i]  <= 1'b0;
            m_left[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (m_busy[i]) begin
               m_left[i] <= m_left[i] - 1;
               if (m_left[i] == 1) begin
                  m_busy[i] <= 1'b0;
                  m_done[i] <= 1'b1;
                  m_out[i]  <= crc_usb(m_data[i], nbytes(i));
                  m_err[i]  <= (crc_usb(m_data[i], nbytes(i)) != m_ci[i]);
               end
            end else if (st[i]) begin
               m_busy[i] <= 1'b1;
               m_done[i] <= 1'b0;
               m_err[i]  <= 1'b0;
               m_data[i] <= (i == 0) ? {8'h00, din[i][63:0]} : din[i];
               m_ci[i]   <= ci[i];
               m_left[i] <= ncyc(i);
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         check($sformatf("busy%0d", i), {31'd0, q_busy[i]}, {31'd0, m_busy[i]});
         check($sformatf("done%0d", i), {31'd0, q_done[i]}, {31'd0, m_done[i]});
         check($sformatf("out%0d", i), {16'd0, q_out[i]}, {16'd0, m_out[i]});
         check($sformatf("overlap%0d", i), {31'd0, q_busy[i] & q_done[i]}, 32'd0);
`ifdef CRC16_TX_CHECK_EN
         check($sformatf("err%0d", i), {31'd0, ce[i]}, {31'd0, m_err[i]});
`endif
      end
   end

   task automatic pulse(input int i, input logic [71:0] d, output int k0);
      @(posedge clk); #1;
      st[i]  = 1'b1;
      din[i] = d;
      @(posedge clk); #1;
      st[i]  = 1'b0;
      k0     = cyc;
   endtask

   task automatic wait_done(input int i, input int k0, input int exp_lat, input string name);
      int n;
      n = 0;
      while (!q_done[i] && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, cyc - k0, exp_lat);
   endtask

   initial begin
      int k0;
      int k1;
      logic [15:0] old;
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         st[i]  = 1'b0;
         din[i] = '0;
         ci[i]  = 16'h0000;
      end
      #1 n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", {16'd0, q_out[0]}, 32'h0);
      check("rst_done", {31'd0, q_done[0]}, 32'h0);
      check("rst_busy", {31'd0, q_busy[0]}, 32'h0);
      check("model_pin", {16'd0, crc_usb(ASCII, 9)}, 32'hB4C8);
      n_rst = 1'b1;

      // Zero payload on the 64-bit instance; a second start mid-run must be ignored.
      pulse(0, 72'h0, k0);
      check("run0_busy", {31'd0, q_busy[0]}, 32'h1);
      repeat (9) @(posedge clk);
      #1;
      st[0]  = 1'b1;
      din[0] = 72'h00_DEADBEEF_CAFEF00D;
      @(posedge clk); #1;
      st[0]  = 1'b0;
      wait_done(0, k0, 64, "lat0");
      check("res0_zero", {16'd0, q_out[0]}, {16'd0, crc_usb(72'h0, 8)});
      check("res0_busy", {31'd0, q_busy[0]}, 32'h0);

      // "123456789" on both 72-bit instances at once.
      ci[1] = 16'hB4C8;
      ci[2] = 16'hB4C9;
      @(posedge clk); #1;
      st[1] = 1'b1; din[1] = ASCII;
      st[2] = 1'b1; din[2] = ASCII;
      @(posedge clk); #1;
      st[1] = 1'b0; st[2] = 1'b0;
      din[1] = '0;  din[2] = '0;
      k1 = cyc;
      wait_done(2, k1, 9, "lat2");
      check("res2_b4c8", {16'd0, q_out[2]}, 32'hB4C8);
      wait_done(1, k1, 72, "lat1");
      check("res1_b4c8", {16'd0, q_out[1]}, 32'hB4C8);
`ifdef CRC16_TX_CHECK_EN
      check("err1_ok", {31'd0, ce[1]}, 32'h0);
      check("err2_bad", {31'd0, ce[2]}, 32'h1);
`endif

      // Restart from DONE: done drops at once, old result held until the new one lands.
      old = crc_usb(72'h0, 8);
      pulse(0, 72'h00_0123456789ABCDEF, k0);
      check("restart_done", {31'd0, q_done[0]}, 32'h0);
      check("restart_hold", {16'd0, q_out[0]}, {16'd0, old});
      repeat (20) @(posedge clk);
      #1;
      check("restart_hold20", {16'd0, q_out[0]}, {16'd0, old});
      wait_done(0, k0, 64, "lat0b");
      check("res0_new", {16'd0, q_out[0]}, {16'd0, crc_usb(72'h00_0123456789ABCDEF, 8)});

      // Reset asserted 20 cycles into a run aborts without publishing.
      pulse(0, 72'h00_FFFFFFFFFFFFFFFF, k0);
      repeat (19) @(posedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      check("abort_busy", {31'd0, q_busy[0]}, 32'h0);
      check("abort_done", {31'd0, q_done[0]}, 32'h0);
      check("abort_out", {16'd0, q_out[0]}, 32'h0);
      check("abort_out1", {16'd0, q_out[1]}, 32'h0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      check("abort_nodone", {31'd0, q_done[0]}, 32'h0);
      check("abort_idle", {31'd0, q_busy[0]}, 32'h0);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
